// File: rtl/bcd_mult_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential BCD multiplier.
interface bcd_mult_seq_if #(
    parameter int unsigned NDIG = 2
);
    logic                  start;
    logic [4*NDIG-1:0]     a;
    logic [4*NDIG-1:0]     b;
    logic                  busy;
    logic                  done;
    logic                  invalid;
    logic [8*NDIG-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, invalid, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, invalid, product
    );
endinterface

// File: rtl/bcd_mult_seq.sv
// Sequential NDIG-digit packed-BCD multiplier using digit-serial repeated BCD addition.
module bcd_mult_seq #(
    parameter int unsigned NDIG = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_mult_seq_if.slave bus
);
    localparam int unsigned OW = 4 * NDIG;
    localparam int unsigned PW = 8 * NDIG;
    localparam int unsigned PD = 2 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADD
    } state_t;

    state_t          state, state_d;
    logic [OW-1:0]   a_q, a_d;
    logic [OW-1:0]   b_q, b_d;
    logic [PW-1:0]   acc, acc_d;
    logic [PW-1:0]   product, product_d;
    logic [3:0]      cnt, cnt_d;
    logic [IW-1:0]   idx, idx_d;
    logic            busy, busy_d;
    logic            done, done_d;
    logic            invalid, invalid_d;

    // True when any digit of an operand is outside 0..9.
    function automatic logic has_bad_digit(input logic [OW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Digit-wise BCD add with +6 correction and rippled decimal carry; final carry is always 0.
    function automatic logic [PW-1:0] bcd_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] s;
        logic          c;
        logic [4:0]    d;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < int'(PD); i++) begin
            d = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        return s;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            product <= '0;
            cnt     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            state   <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc     <= acc_d;
            product <= product_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            invalid <= invalid_d;
        end
    end

    // Next-state and next-output logic; done defaults low so it pulses for one cycle.
    always_comb begin
        state_d   = state;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc;
        product_d = product;
        cnt_d     = cnt;
        idx_d     = idx;
        busy_d    = busy;
        done_d    = 1'b0;
        invalid_d = invalid;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
                        done_d    = 1'b1;
                        invalid_d = 1'b1;
                        product_d = '0;
                    end else begin
                        acc_d   = '0;
                        idx_d   = IW'(NDIG - 1);
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d   = {acc[PW-5:0], 4'd0};
                cnt_d   = b_q[4*int'(idx) +: 4];
                state_d = ADD;
            end
            ADD: begin
                if (cnt != 4'd0) begin
                    acc_d = bcd_add(acc, PW'(a_q));
                    cnt_d = cnt - 4'd1;
                end else if (idx != '0) begin
                    idx_d   = idx - IW'(1);
                    state_d = SHIFT;
                end else begin
                    product_d = acc;
                    done_d    = 1'b1;
                    invalid_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.invalid = invalid;
    assign bus.product = product;
endmodule

// File: tb/tb_bcd_mult_seq.sv
// Directed bench for bcd_mult_seq: NDIG=2 scenarios plus an NDIG=1 exhaustive digit sweep.
module tb_bcd_mult_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    bcd_mult_seq_if #(.NDIG(2)) bus2 ();
    bcd_mult_seq_if #(.NDIG(1)) bus1 ();

    bcd_mult_seq #(.NDIG(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    bcd_mult_seq #(.NDIG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Wait for done on the NDIG=2 unit; lat counts edges after the start edge.
    task automatic wait2(output int lat, output logic ok, output logic bmin, output logic bany);
        lat  = 0;
        ok   = 1'b0;
        bmin = 1'b1;
        bany = 1'b0;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        while (lat <= 300) begin
            bany = bany | bus2.busy;
            if (bus2.done) begin
                ok = 1'b1;
                break;
            end
            bmin = bmin & bus2.busy;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait1(output int lat, output logic ok);
        lat = 0;
        ok  = 1'b0;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        while (lat <= 300) begin
            if (bus1.done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic start2(input logic [7:0] av, input logic [7:0] bv);
        bus2.a     = av;
        bus2.b     = bv;
        bus2.start = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus2.busy, bus2.done, bus2.invalid} !== 3'b000 || bus2.product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ndig2: busy=%b done=%b invalid=%b product=%h, expected all 0",
                     bus2.busy, bus2.done, bus2.invalid, bus2.product);
        end
        vectors++;
        if ({bus1.busy, bus1.done, bus1.invalid} !== 3'b000 || bus1.product !== 8'h00) begin
            errors++;
            $display("FAIL reset_ndig1: busy=%b done=%b invalid=%b product=%h, expected all 0",
                     bus1.busy, bus1.done, bus1.invalid, bus1.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0]  av [3] = '{8'h12, 8'h99, 8'h00};
        logic [7:0]  bv [3] = '{8'h34, 8'h99, 8'h00};
        logic [15:0] ev [3] = '{16'h0408, 16'h9801, 16'h0000};
        int          el [3] = '{11, 22, 4};
        int          lat;
        logic        ok, bmin, bany;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start2(av[i], bv[i]);
            wait2(lat, ok, bmin, bany);
            vectors++;
            if (!ok || lat != el[i]) begin
                errors++;
                $display("FAIL basic_latency %h*%h: done=%b after %0d edges, expected %0d", av[i], bv[i], ok, lat, el[i]);
            end
            vectors++;
            if (bus2.product !== ev[i] || bus2.invalid !== 1'b0) begin
                errors++;
                $display("FAIL basic_product %h*%h: product=%h invalid=%b, expected %h invalid=0",
                         av[i], bv[i], bus2.product, bus2.invalid, ev[i]);
            end
            vectors++;
            if (bmin !== 1'b1 || bus2.busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy %h*%h: busy_through_run=%b busy_at_done=%b, expected 1 and 0",
                         av[i], bv[i], bmin, bus2.busy);
            end
            @(posedge clk); #1;
            vectors++;
            if (bus2.done !== 1'b0 || bus2.product !== ev[i]) begin
                errors++;
                $display("FAIL basic_done_pulse %h*%h: done=%b product=%h one cycle later, expected 0 and %h",
                         av[i], bv[i], bus2.done, bus2.product, ev[i]);
            end
        end
    endtask

    task automatic test_invalid;
        int   lat;
        logic ok, bmin, bany;
        @(negedge clk);
        start2(8'h1A, 8'h05);
        wait2(lat, ok, bmin, bany);
        vectors++;
        if (!ok || lat != 0 || bus2.invalid !== 1'b1 || bus2.product !== 16'h0000 || bany !== 1'b0) begin
            errors++;
            $display("FAIL invalid_flag: done=%b lat=%0d invalid=%b product=%h busy_seen=%b, expected 1 0 1 0000 0",
                     ok, lat, bus2.invalid, bus2.product, bany);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus2.done !== 1'b0 || bus2.invalid !== 1'b1) begin
            errors++;
            $display("FAIL invalid_sticky: done=%b invalid=%b, expected 0 1", bus2.done, bus2.invalid);
        end
        @(negedge clk);
        start2(8'h05, 8'h05);
        wait2(lat, ok, bmin, bany);
        vectors++;
        if (!ok || lat != 9 || bus2.product !== 16'h0025 || bus2.invalid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_recover: done=%b lat=%0d product=%h invalid=%b, expected 1 9 0025 0",
                     ok, lat, bus2.product, bus2.invalid);
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        logic ok, bmin, bany;
        @(negedge clk);
        start2(8'h50, 8'h50);
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = 0;
        ok  = 1'b0;
        while (lat <= 300) begin
            if (lat == 2) start2(8'h11, 8'h11);
            if (lat == 3) bus2.start = 1'b0;
            if (bus2.done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (!ok || lat != 9 || bus2.product !== 16'h2500) begin
            errors++;
            $display("FAIL busy_ignore: done=%b lat=%0d product=%h, expected 1 9 2500", ok, lat, bus2.product);
        end
        start2(8'h03, 8'h02);
        wait2(lat, ok, bmin, bany);
        vectors++;
        if (!ok || lat != 6 || bus2.product !== 16'h0006 || bmin !== 1'b1) begin
            errors++;
            $display("FAIL start_on_done: done=%b lat=%0d product=%h busy=%b, expected 1 6 0006 1",
                     ok, lat, bus2.product, bmin);
        end
    endtask

    task automatic test_abort;
        int   lat;
        int   done_cnt;
        int   busy_cnt;
        logic ok, bmin, bany;
        @(negedge clk);
        start2(8'h9B, 8'h01);
        wait2(lat, ok, bmin, bany);
        @(negedge clk);
        start2(8'h99, 8'h99);
        @(posedge clk); #1;
        bus2.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus2.busy, bus2.done, bus2.invalid} !== 3'b000 || bus2.product !== 16'h0000) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b invalid=%b product=%h, expected all 0",
                     bus2.busy, bus2.done, bus2.invalid, bus2.product);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus2.done) done_cnt++;
            if (bus2.busy) busy_cnt++;
        end
        vectors++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_done: done cycles=%0d busy cycles=%0d, expected 0 0", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_ndig1;
        int         lat;
        logic       ok;
        logic [7:0] exp_p;
        @(negedge clk);
        bus1.a = 4'h7; bus1.b = 4'h8; bus1.start = 1'b1;
        wait1(lat, ok);
        vectors++;
        if (!ok || lat != 10 || bus1.product !== 8'h56) begin
            errors++;
            $display("FAIL ndig1_7x8: done=%b lat=%0d product=%h, expected 1 10 56", ok, lat, bus1.product);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                exp_p = {4'((i * j) / 10), 4'((i * j) % 10)};
                @(negedge clk);
                bus1.a = 4'(i); bus1.b = 4'(j); bus1.start = 1'b1;
                wait1(lat, ok);
                vectors++;
                if (!ok || lat != 2 + j || bus1.product !== exp_p || bus1.invalid !== 1'b0) begin
                    errors++;
                    $display("FAIL ndig1_sweep %0d*%0d: done=%b lat=%0d product=%h invalid=%b, expected 1 %0d %h 0",
                             i, j, ok, lat, bus1.product, bus1.invalid, 2 + j, exp_p);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        test_reset();
        test_basic();
        test_invalid();
        test_back_to_back();
        test_abort();
        test_ndig1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
